// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      func3_in,
  input  logic [6:0]      func7_in,
  input  logic [XLEN-1:0] rs1_val_in,
  input  logic [XLEN-1:0] rs2_val_in,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic            start;
  logic            a_signed, b_signed, neg_a_in, neg_b_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_a, neg_b, b_zero;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_nxt, prod_signed;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_signed, rem_signed, final_val;
  logic              finish;

  assign start = valid_in & (opcode_in == 7'b0110011) & (func7_in == 7'b0000001)
               & (state == IDLE) & ~flush;

  // Operand sign interpretation: MULHU/DIVU/REMU are fully unsigned, MULHSU only signs rs1
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (func3_in)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:                   a_signed = 1'b1;
      default:                ;
    endcase
    neg_a_in = a_signed & rs1_val_in[XLEN-1];
    neg_b_in = b_signed & rs2_val_in[XLEN-1];
    a_mag_in = neg_a_in ? -rs1_val_in : rs1_val_in;
    b_mag_in = neg_b_in ? -rs2_val_in : rs2_val_in;
  end

  // One shift-add multiply step and one restoring divide step; both run every BUSY cycle
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
    prod_nxt  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    rem_nxt   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    quo_nxt   = {quo[XLEN-2:0], ~div_diff[XLEN]};
  end

  // Sign fix-up and selection of the final value from the last iteration's outputs
  always_comb begin
    prod_signed = (neg_a ^ neg_b) ? -prod_nxt : prod_nxt;
    quo_signed  = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo_nxt : quo_nxt);
    rem_signed  = neg_a ? -rem_nxt : rem_nxt;
    case (f3_q)
      3'd0:       final_val = prod_signed[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       final_val = prod_signed[2*XLEN-1:XLEN];
      3'd4, 3'd5: final_val = quo_signed;
      default:    final_val = rem_signed;
    endcase
  end

  assign finish = (state == BUSY) & (cnt == LAST) & ~flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so the held instruction cannot restart
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; flush in DONE kills the strobe
  always_comb begin
    stall        = ((state == IDLE) & start) | (state == BUSY);
    busy         = (state == BUSY);
    result_valid = (state == DONE) & ~flush;
  end

  // Operand latch, iteration registers and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q   <= '0;
      rd_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      cnt    <= '0;
      prod   <= '0;
      quo    <= '0;
      rem    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      if (start) begin
        f3_q   <= func3_in;
        rd_q   <= rd_in;
        neg_a  <= neg_a_in;
        neg_b  <= neg_b_in;
        b_zero <= (rs2_val_in == '0);
        a_mag  <= a_mag_in;
        b_mag  <= b_mag_in;
        cnt    <= '0;
        prod   <= {{XLEN{1'b0}}, b_mag_in};
        quo    <= a_mag_in;
        rem    <= '0;
      end else if (state == BUSY) begin
        cnt  <= cnt + 1'b1;
        prod <= prod_nxt;
        quo  <= quo_nxt;
        rem  <= rem_nxt;
      end
      if (finish) begin
        result <= final_val;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [6:0]  opcode_in = '0;
  logic [2:0]  func3_in = '0;
  logic [6:0]  func7_in = '0;
  logic [31:0] rs1_val_in = '0;
  logic [31:0] rs2_val_in = '0;
  logic [4:0]  rd_in = '0;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
    .opcode_in(opcode_in), .func3_in(func3_in), .func7_in(func7_in),
    .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in), .rd_in(rd_in),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    int ia, ib;
    sa = (f3 == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    sb = (f3 == 3'd2 || f3 == 3'd3) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = sa * sb;
    ia = a;
    ib = b;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    valid_in = 1'b1; opcode_in = 7'b0110011; func7_in = 7'b0000001;
    func3_in = f3; rs1_val_in = a; rs2_val_in = b; rd_in = rd;
  endtask

  // Called just after a falling edge; returns in the DONE cycle with inputs still held
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    int early = 0;
    logic [31:0] exp;
    exp = ref_op(f3, a, b);
    drive(f3, a, b, rd);
    #1;
    while (stall && n < 100) begin
      n++;
      if (result_valid) early++;
      @(negedge clk); #1;
    end
    tests++;
    if (n !== 33) begin fails++; $display("FAIL %s stall_cycles got %0d want 33", name, n); end
    tests++;
    if (early !== 0) begin fails++; $display("FAIL %s early_valid got %0d want 0", name, early); end
    tests++;
    if (result_valid !== 1'b1) begin fails++; $display("FAIL %s result_valid got %b want 1", name, result_valid); end
    tests++;
    if (result !== exp) begin
      fails++; $display("FAIL %s result f3=%0d a=%h b=%h got %h want %h", name, f3, a, b, result, exp);
    end
    tests++;
    if (rd_out !== rd) begin fails++; $display("FAIL %s rd_out got %0d want %0d", name, rd_out, rd); end
  endtask

  task automatic idle(input string name);
    logic [31:0] held;
    held = result;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL %s idle_after_done rv=%b busy=%b stall=%b want 0 0 0", name, result_valid, busy, stall);
    end
    tests++;
    if (result !== held) begin fails++; $display("FAIL %s result_hold got %h want %h", name, result, held); end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset outputs busy=%b rv=%b result=%h rd=%0d stall=%b want all 0",
                        busy, result_valid, result, rd_out, stall);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    @(negedge clk); run_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd3); idle("mul_neg");
    @(negedge clk); run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 5'd4); idle("mulh");
    @(negedge clk); run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5); idle("mulhu");
    @(negedge clk); run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6); idle("mulhsu");
    @(negedge clk); run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd7); idle("div");
    @(negedge clk); run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd8); idle("rem");
    @(negedge clk); run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9); idle("divu");
    @(negedge clk); run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10); idle("remu");
  endtask

  task automatic test_special();
    @(negedge clk); run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd11); idle("divu_by0");
    @(negedge clk); run_op("remu_by0", 3'd7, 32'd5, 32'd0, 5'd12); idle("remu_by0");
    @(negedge clk); run_op("div_by0", 3'd4, 32'hFFFFFFF0, 32'd0, 5'd13); idle("div_by0");
    @(negedge clk); run_op("rem_by0", 3'd6, 32'hFFFFFFF0, 32'd0, 5'd14); idle("rem_by0");
    @(negedge clk); run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15); idle("div_ovf");
    @(negedge clk); run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16); idle("rem_ovf");
  endtask

  task automatic test_flush();
    int seen = 0;
    int n = 0;
    @(negedge clk);
    drive(3'd0, 32'd12, 32'd13, 5'd20);
    repeat (11) @(negedge clk);
    flush = 1'b1; valid_in = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0) begin
      fails++; $display("FAIL flush_busy busy=%b stall=%b rv=%b want 0 0 0", busy, stall, result_valid);
    end
    flush = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (result_valid) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL flush_no_result got %0d strobes want 0", seen); end
    // flush coinciding with a start in IDLE wins
    @(negedge clk);
    drive(3'd1, 32'd3, 32'd4, 5'd21); flush = 1'b1; #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_start_stall got %b want 0", stall); end
    @(negedge clk); valid_in = 1'b0; flush = 1'b0; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_busy got %b want 0", busy); end
    // flush during DONE suppresses the strobe
    @(negedge clk);
    drive(3'd5, 32'd50, 32'd5, 5'd22); #1;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    flush = 1'b1; #1;
    tests++;
    if (result_valid !== 1'b0 || n !== 33) begin
      fails++; $display("FAIL flush_done rv=%b stall_cycles=%0d want 0 33", result_valid, n);
    end
    @(negedge clk); flush = 1'b0; valid_in = 1'b0; #1;
    tests++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      fails++; $display("FAIL flush_done_idle busy=%b rv=%b want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(3'd0, 32'd9, 32'd9, 5'd23);
    repeat (21) @(negedge clk);
    #2;
    rst = 1'b1; valid_in = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      fails++; $display("FAIL async_reset busy=%b stall=%b rv=%b result=%h rd=%0d want all 0",
                        busy, stall, result_valid, result, rd_out);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); run_op("after_reset", 3'd7, 32'd1000, 32'd33, 5'd24); idle("after_reset");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); run_op("b2b_0", 3'd0, 32'd123, 32'd456, 5'd1);
    @(negedge clk); run_op("b2b_1", 3'd4, 32'hFFFFFF00, 32'd16, 5'd2);
    @(negedge clk); run_op("b2b_2", 3'd3, 32'hDEADBEEF, 32'hCAFEBABE, 5'd31);
    idle("b2b_end");
  endtask

  task automatic test_non_m();
    int hits = 0;
    @(negedge clk);
    drive(3'd0, 32'd1, 32'd2, 5'd5);
    func7_in = 7'b0000000;
    repeat (5) begin #1; if (stall || busy) hits++; @(negedge clk); end
    opcode_in = 7'b0010011; func7_in = 7'b0000001;
    repeat (5) begin #1; if (stall || busy) hits++; @(negedge clk); end
    valid_in = 1'b0; opcode_in = 7'b0110011;
    repeat (5) begin #1; if (stall || busy) hits++; @(negedge clk); end
    tests++;
    if (hits !== 0) begin fails++; $display("FAIL non_m_stall got %0d stalled cycles want 0", hits); end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [5];
    specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;
    if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
    return $urandom;
  endfunction

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(7)); a = pick(); b = pick(); rd = 5'($urandom_range(31));
      @(negedge clk);
      run_op($sformatf("rand%0d", i), f3, a, b, rd);
      if ($urandom_range(1) == 0) idle($sformatf("rand%0d", i));
    end
    idle("rand_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_non_m();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
